// File: rtl/rob_commit_if.sv
// Dispatch / completion / retire bundle for rob_commit.
// master: dispatch, completion units and the register file side.
// slave : the reorder buffer itself.
// Signals: alloc_* (dispatch request and tag return), cmpl_*1/2 (two
// completion ports), arf_write_* and retire_count (retire to ARF),
// rob_empty, and flush when ROB_FLUSH_EN is defined.
interface rob_commit_if #(
  parameter int unsigned ROB_IDX = 4,
  parameter int unsigned AR_SIZE = 6
) ();
  logic               alloc_valid;
  logic [AR_SIZE-1:0] alloc_rd;
  logic               alloc_has_rd;
  logic               alloc_ready;
  logic [ROB_IDX-1:0] alloc_tag;

  logic               cmpl_valid1;
  logic [ROB_IDX-1:0] cmpl_tag1;
  logic [31:0]        cmpl_data1;
  logic               cmpl_valid2;
  logic [ROB_IDX-1:0] cmpl_tag2;
  logic [31:0]        cmpl_data2;

  logic [AR_SIZE-1:0] arf_write_addr1;
  logic [31:0]        arf_write_data1;
  logic [AR_SIZE-1:0] arf_write_addr2;
  logic [31:0]        arf_write_data2;
  logic               arf_write_en;
  logic [1:0]         retire_count;
  logic               rob_empty;
`ifdef ROB_FLUSH_EN
  logic               flush;
`endif

  modport master (
    output alloc_valid, alloc_rd, alloc_has_rd,
    output cmpl_valid1, cmpl_tag1, cmpl_data1,
    output cmpl_valid2, cmpl_tag2, cmpl_data2,
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    input  alloc_ready, alloc_tag,
    input  arf_write_addr1, arf_write_data1, arf_write_addr2, arf_write_data2,
    input  arf_write_en, retire_count, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_has_rd,
    input  cmpl_valid1, cmpl_tag1, cmpl_data1,
    input  cmpl_valid2, cmpl_tag2, cmpl_data2,
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    output alloc_ready, alloc_tag,
    output arf_write_addr1, arf_write_data1, arf_write_addr2, arf_write_data2,
    output arf_write_en, retire_count, rob_empty
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order dual retire.
// Ports: clk, rstn (synchronous, active-low), rob (rob_commit_if.slave).
// Allocates one entry per dispatch at the tail, accepts two completion
// ports (port 2 wins on a same-tag collision), retires up to two done
// entries per cycle from the head into the ARF dual write port.
// alloc_ready, alloc_tag and rob_empty are combinational from the
// pointers; all other outputs are registered.
// Optional feature: ROB_FLUSH_EN adds rob.flush, which empties the buffer.
module rob_commit #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned ROB_IDX   = 4,
  parameter int unsigned AR_SIZE   = 6
) (
  input logic        clk,
  input logic        rstn,
  rob_commit_if.slave rob
);
  localparam int unsigned PTR_W = ROB_IDX + 1;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_done;
  logic [ROB_DEPTH-1:0] ent_has_rd;
  logic [AR_SIZE-1:0] ent_rd   [ROB_DEPTH];
  logic [31:0]        ent_data [ROB_DEPTH];

  logic [ROB_IDX-1:0] head_idx;
  logic [ROB_IDX-1:0] head_idx1;
  logic [ROB_IDX-1:0] tail_idx;
  logic               full_c;
  logic               alloc_fire_c;
  logic               cmpl1_ok_c;
  logic               cmpl2_ok_c;
  logic               ret1_c;
  logic               ret2_c;
  logic [1:0]         ret_n_c;
  logic               flush_c;

`ifdef ROB_FLUSH_EN
  assign flush_c = rob.flush;
`else
  assign flush_c = 1'b0;
`endif

  // Pointer decode; the extra MSB separates full from empty
  assign head_idx  = head[ROB_IDX-1:0];
  assign head_idx1 = head_idx + ROB_IDX'(1);
  assign tail_idx  = tail[ROB_IDX-1:0];
  assign full_c    = (head_idx == tail_idx) && (head[ROB_IDX] != tail[ROB_IDX]);

  assign rob.alloc_ready = !full_c;
  assign rob.alloc_tag   = tail_idx;
  assign rob.rob_empty   = (head == tail);

  assign alloc_fire_c = rob.alloc_valid && !full_c;

  // Completions to entries that are not live are dropped
  assign cmpl1_ok_c = rob.cmpl_valid1 && ent_valid[rob.cmpl_tag1];
  assign cmpl2_ok_c = rob.cmpl_valid2 && ent_valid[rob.cmpl_tag2];

  // Retire decision from pre-edge state; slot 2 only behind slot 1
  assign ret1_c  = ent_valid[head_idx] && ent_done[head_idx];
  assign ret2_c  = ret1_c && ent_valid[head_idx1] && ent_done[head_idx1];
  assign ret_n_c = {1'b0, ret1_c} + {1'b0, ret2_c};

  // Control state, pointers and registered retire outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head                <= '0;
      tail                <= '0;
      ent_valid           <= '0;
      ent_done            <= '0;
      rob.arf_write_en    <= 1'b0;
      rob.arf_write_addr1 <= '0;
      rob.arf_write_data1 <= '0;
      rob.arf_write_addr2 <= '0;
      rob.arf_write_data2 <= '0;
      rob.retire_count    <= '0;
    end else if (flush_c) begin
      ent_valid           <= '0;
      ent_done            <= '0;
      tail                <= head;
      rob.arf_write_en    <= 1'b0;
      rob.arf_write_addr1 <= '0;
      rob.arf_write_data1 <= '0;
      rob.arf_write_addr2 <= '0;
      rob.arf_write_data2 <= '0;
      rob.retire_count    <= '0;
    end else begin
      rob.arf_write_en    <= ret1_c;
      rob.retire_count    <= ret_n_c;
      rob.arf_write_addr1 <= (ret1_c && ent_has_rd[head_idx])  ? ent_rd[head_idx]    : '0;
      rob.arf_write_data1 <= (ret1_c && ent_has_rd[head_idx])  ? ent_data[head_idx]  : '0;
      rob.arf_write_addr2 <= (ret2_c && ent_has_rd[head_idx1]) ? ent_rd[head_idx1]   : '0;
      rob.arf_write_data2 <= (ret2_c && ent_has_rd[head_idx1]) ? ent_data[head_idx1] : '0;

      if (cmpl1_ok_c) ent_done[rob.cmpl_tag1] <= 1'b1;
      if (cmpl2_ok_c) ent_done[rob.cmpl_tag2] <= 1'b1;
      if (ret1_c) begin
        ent_valid[head_idx] <= 1'b0;
        ent_done[head_idx]  <= 1'b0;
      end
      if (ret2_c) begin
        ent_valid[head_idx1] <= 1'b0;
        ent_done[head_idx1]  <= 1'b0;
      end
      // Tail slot is never live when not full, so no overlap with retire
      if (alloc_fire_c) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_done[tail_idx]  <= 1'b0;
      end

      head <= head + PTR_W'(ret_n_c);
      tail <= tail + PTR_W'(alloc_fire_c);
    end
  end

  // Entry payload; meaningful only while the valid bit is set
  always_ff @(posedge clk) begin
    if (cmpl1_ok_c) ent_data[rob.cmpl_tag1] <= rob.cmpl_data1;
    if (cmpl2_ok_c) ent_data[rob.cmpl_tag2] <= rob.cmpl_data2;
    if (alloc_fire_c) begin
      ent_rd[tail_idx]     <= rob.alloc_rd;
      ent_has_rd[tail_idx] <= rob.alloc_has_rd;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected retire
// records tagged with the cycle they must appear in; a negedge monitor
// pops and compares, and requires idle outputs on every other cycle.
module tb_rob_commit;
  logic clk;
  logic rstn;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  typedef struct {
    int          cyc;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [5:0]  a2;
    logic [31:0] d2;
    logic [1:0]  n;
  } exp_t;
  exp_t q[$];

  rob_commit_if #(.ROB_IDX(4), .AR_SIZE(6)) bus ();

  rob_commit #(.ROB_DEPTH(16), .ROB_IDX(4), .AR_SIZE(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rob  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: exact-cycle retire compare, otherwise outputs must be idle
  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_retire: no retire at expected cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("arf_write_en", 32'(bus.arf_write_en), 32'd1);
        check("retire_count", 32'(bus.retire_count), 32'(e.n));
        check("addr1", 32'(bus.arf_write_addr1), 32'(e.a1));
        check("data1", bus.arf_write_data1, e.d1);
        check("addr2", 32'(bus.arf_write_addr2), 32'(e.a2));
        check("data2", bus.arf_write_data2, e.d2);
      end else begin
        check("idle_outputs",
              {bus.arf_write_en, bus.retire_count, bus.arf_write_addr1, bus.arf_write_addr2,
               (bus.arf_write_data1 | bus.arf_write_data2) != 32'd0 ? 1'b1 : 1'b0},
              32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] a1, input logic [31:0] d1,
                      input logic [5:0] a2, input logic [31:0] d2, input logic [1:0] n);
    exp_t e;
    e.cyc = cyc + 2; e.a1 = a1; e.d1 = d1; e.a2 = a2; e.d2 = d2; e.n = n;
    q.push_back(e);
  endtask

  task automatic do_alloc(input logic [5:0] rd, input logic has);
    bus.alloc_valid  = 1'b1;
    bus.alloc_rd     = rd;
    bus.alloc_has_rd = has;
    tick();
    bus.alloc_valid  = 1'b0;
  endtask

  task automatic do_cmpl(input logic v1, input logic [3:0] t1, input logic [31:0] d1,
                         input logic v2, input logic [3:0] t2, input logic [31:0] d2);
    bus.cmpl_valid1 = v1; bus.cmpl_tag1 = t1; bus.cmpl_data1 = d1;
    bus.cmpl_valid2 = v2; bus.cmpl_tag2 = t2; bus.cmpl_data2 = d2;
    tick();
    bus.cmpl_valid1 = 1'b0;
    bus.cmpl_valid2 = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0; bus.alloc_has_rd = 1'b0;
    bus.cmpl_valid1 = 1'b0; bus.cmpl_tag1 = '0; bus.cmpl_data1 = '0;
    bus.cmpl_valid2 = 1'b0; bus.cmpl_tag2 = '0; bus.cmpl_data2 = '0;
`ifdef ROB_FLUSH_EN
    bus.flush = 1'b0;
`endif
    tick();
    tick();
    rstn   = 1'b1;
    mon_on = 1'b1;

    // Reset state
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_alloc_tag",   32'(bus.alloc_tag),   32'd0);
    check("rst_rob_empty",   32'(bus.rob_empty),   32'd1);

    // Single instruction
    do_alloc(6'd5, 1'b1);
    check("t1_not_empty", 32'(bus.rob_empty), 32'd0);
    check("t1_tag_next",  32'(bus.alloc_tag), 32'd1);
    push(6'd5, 32'hDEADBEEF, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    tick(); tick();
    check("t1_empty_after", 32'(bus.rob_empty), 32'd1);

    // Out-of-order completion, in-order dual retire
    do_reset();
    do_alloc(6'd1, 1'b1);
    do_alloc(6'd2, 1'b1);
    do_alloc(6'd3, 1'b1);
    do_cmpl(1'b1, 4'd2, 32'hA2, 1'b0, 4'd0, 32'd0);
    do_cmpl(1'b1, 4'd1, 32'hA1, 1'b0, 4'd0, 32'd0);
    tick();
    push(6'd1, 32'hA0, 6'd2, 32'hA1, 2'd2);
    q.push_back('{cyc + 3, 6'd3, 32'hA2, 6'd0, 32'd0, 2'd1});
    do_cmpl(1'b1, 4'd0, 32'hA0, 1'b0, 4'd0, 32'd0);
    tick(); tick(); tick();
    check("t2_empty", 32'(bus.rob_empty), 32'd1);

    // Fill to capacity, rejected 17th request, wrap of alloc_tag
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(6'(i + 10), 1'b1);
    check("t3_full_ready", 32'(bus.alloc_ready), 32'd0);
    check("t3_full_tag",   32'(bus.alloc_tag),   32'd0);
    do_alloc(6'd63, 1'b1);
    check("t3_ignored_ready", 32'(bus.alloc_ready), 32'd0);
    check("t3_ignored_empty", 32'(bus.rob_empty),   32'd0);
    push(6'd10, 32'h100, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b1, 4'd0, 32'h100, 1'b0, 4'd0, 32'd0);
    check("t3_ready_before_retire", 32'(bus.alloc_ready), 32'd0);
    tick();
    check("t3_ready_after_retire", 32'(bus.alloc_ready), 32'd1);
    check("t3_wrap_tag",           32'(bus.alloc_tag),   32'd0);

    // Drain tags 1..14 in pairs, leaving head at 15
    for (int j = 0; j < 7; j++) begin
      push(6'(2 * j + 11), 32'h200 + 32'(2 * j + 1), 6'(2 * j + 12), 32'h200 + 32'(2 * j + 2), 2'd2);
      do_cmpl(1'b1, 4'(2 * j + 1), 32'h200 + 32'(2 * j + 1),
              1'b1, 4'(2 * j + 2), 32'h200 + 32'(2 * j + 2));
    end
    tick(); tick();
    do_alloc(6'd40, 1'b1);
    check("t4_tag_after_wrap", 32'(bus.alloc_tag), 32'd1);
    push(6'd25, 32'h3F, 6'd40, 32'h40, 2'd2);
    do_cmpl(1'b1, 4'd15, 32'h3F, 1'b1, 4'd0, 32'h40);
    tick(); tick();
    check("t4_empty", 32'(bus.rob_empty), 32'd1);

    // Same-tag collision, no-destination entry, dropped completion
    do_reset();
    do_alloc(6'd7, 1'b1);
    do_alloc(6'd8, 1'b0);
    push(6'd7, 32'h22, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
    tick();
    push(6'd0, 32'd0, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b1, 4'd1, 32'h99, 1'b0, 4'd0, 32'd0);
    tick(); tick();
    do_cmpl(1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 32'd0);
    do_alloc(6'd9, 1'b1);
    tick(); tick(); tick();
    check("t5_dropped_pending", 32'(bus.rob_empty), 32'd0);
    push(6'd9, 32'h66, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h66);
    tick(); tick();

    // Reset on the retire-decision edge discards the entry
    do_alloc(6'd3, 1'b1);
    do_cmpl(1'b1, 4'd3, 32'h77, 1'b0, 4'd0, 32'd0);
    do_reset();
    tick(); tick();
    check("t6_empty", 32'(bus.rob_empty), 32'd1);
    check("t6_tag",   32'(bus.alloc_tag), 32'd0);

`ifdef ROB_FLUSH_EN
    // Flush on the edge where the head would retire
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(6'(i + 1), 1'b1);
    do_cmpl(1'b1, 4'd1, 32'hB1, 1'b1, 4'd2, 32'hB2);
    do_cmpl(1'b1, 4'd0, 32'hB0, 1'b0, 4'd0, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick(); tick();
    check("t7_flush_empty", 32'(bus.rob_empty), 32'd1);
    check("t7_flush_tag",   32'(bus.alloc_tag), 32'd0);
    do_alloc(6'd9, 1'b1);
    push(6'd9, 32'hC0, 6'd0, 32'd0, 2'd1);
    do_cmpl(1'b1, 4'd0, 32'hC0, 1'b0, 4'd0, 32'd0);
    tick(); tick();
`endif

    tick(); tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit stage for the out-of-order core. Allocates one entry per dispatched instruction, records results from two completion ports, and retires up to two completed instructions per cycle in program order. Retirement drives the architectural register file's dual write port.

## Interface
- ROB_DEPTH, 16, number of entries (power of two)
- ROB_IDX, 4, log2(ROB_DEPTH), tag width
- AR_SIZE, 6, architectural register address width
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_rd  in  AR_SIZE  destination architectural register
- alloc_has_rd  in  1  instruction writes a register
- alloc_ready  out  1  entry available (count < ROB_DEPTH)
- alloc_tag  out  ROB_IDX  tag of the entry the current request receives (tail index)
- cmpl_valid1/2  in  1  completion port valid
- cmpl_tag1/2  in  ROB_IDX  completing entry
- cmpl_data1/2  in  32  result value
- arf_write_addr1/2  out  AR_SIZE  retire slot 1/2 destination; 0 when the slot is unused or the instruction has no destination
- arf_write_data1/2  out  32  retire slot 1/2 data; 0 when unused
- arf_write_en  out  1  at least one slot retired
- retire_count  out  2  instructions retired this cycle (0..2)
- rob_empty  out  1  count == 0

## Operation
- Storage per entry: valid, done, has_rd, rd[AR_SIZE-1:0], data[31:0].
- Pointers: head and tail, ROB_IDX+1 bits each. Full when the indices match and the MSBs differ. Empty when the pointers are equal. count = tail - head, modulo 2^(ROB_IDX+1).
- Allocate when alloc_valid && alloc_ready: write the entry at tail with valid=1, done=0, has_rd, rd. Increment tail. alloc_valid while alloc_ready=0 is ignored, and no state changes.
- Completion: cmpl_validN with a valid entry at cmpl_tagN sets done=1 and writes data. If the target entry is not valid, the completion is dropped. If both ports target the same tag in one cycle, port 2 wins.
- Retire slot 1: the entry at head, if valid && done.
- Retire slot 2: the entry at head+1, only if slot 1 retires and that entry is valid && done.
- Retired entries have valid=0. Head advances by retire_count.
- An entry with has_rd=0 retires with address 0 and data 0. The downstream register file ignores address 0.
- Same-entry hazards: allocate and retire in the same cycle are both legal.
- alloc_ready uses the pre-edge count. A retire does not free a slot for allocation in the same cycle.
- Pointer wrap-around at ROB_DEPTH is seamless. Both retire slots may straddle the wrap.

## Timing
- All outputs are registered except alloc_ready, alloc_tag and rob_empty. Those three are combinational from registered pointers.
- Completion at edge N sets done. The earliest retirement is decided at edge N+1. The ARF write outputs are valid during the cycle after edge N+1, for exactly one cycle.
- The retire decision uses done/valid as of before the edge. A completion arriving in the same cycle as the retire check retires one edge later.
- Allocation at edge N makes the entry completable from the cycle after edge N.
- Reset values:
  - Pointers = 0; all entries invalid and done=0.
  - arf_write_en = 0; arf_write_addr1/2 = 0; arf_write_data1/2 = 0; retire_count = 0.
  - Therefore alloc_ready = 1, alloc_tag = 0, rob_empty = 1.
- Reset asserted mid-operation discards all in-flight entries at that edge, with no ARF write.

## Configuration
- ROB_FLUSH_EN defined:
  - Adds input flush (1 bit).
  - flush=1 at an edge clears all valid/done bits, sets tail = head, and forces the ARF write outputs to zero for the following cycle.
  - Flush takes priority over allocate, complete and retire in that cycle.
- ROB_FLUSH_EN undefined: no flush port; entries leave only by retirement or reset.

## Test plan
- Reset, then allocate rd=5, then complete tag 0 with 0xDEADBEEF.
  - Required: one cycle with arf_write_en=1, addr1=5, data1=0xDEADBEEF, addr2=0, retire_count=1; rob_empty=1 afterwards.
- Allocate tags 0,1,2 (rd=1,2,3). Complete 2, then 1, then 0 on consecutive cycles.
  - Required: nothing retires until tag 0 is done.
  - Then one cycle retires tags 0 and 1 (addr 1,2, retire_count=2).
  - The next cycle retires tag 2 (addr1=3).
- Allocate 16 entries with no completions.
  - Required: alloc_ready=0, and a 17th alloc_valid is ignored.
  - Completing tag 0 and retiring it re-asserts alloc_ready the cycle after the retire; the next alloc_tag is 0 (wrap).
- Complete tag 15 and tag 0 with the head at 15.
  - Required: both retire in one cycle across the wrap, with the correct addresses.
- Complete the same tag on both ports (data 0x11 on port 1, 0x22 on port 2).
  - Required: the retired data is 0x22.
  - A completion to an invalid tag causes no retirement.
- With ROB_FLUSH_EN: allocate 4 entries, complete 2, then assert flush.
  - Required: no ARF write occurs, rob_empty=1, and alloc_tag equals the old head index.
